// File: rtl/saber_pkg.sv
// Shared types and constants for the Saber vector-multiply sequencer.
// Strides are in memory words; ranks cover LightSaber through FireSaber.
package saber_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_RDOUT,
        ST_DONE
    } state_e;

    localparam int POL_STRIDE_PACKED = 52;
    localparam int POL_STRIDE_4X     = 64;
    localparam int SEC_STRIDE        = 16;
    localparam int POLY_WORDS        = 64;
    localparam int L_RANK_MIN        = 2;
    localparam int L_RANK_MAX        = 4;
    // row/col counters only ever reach L_RANK_MAX-1
    localparam int IDX_W             = $clog2(L_RANK_MAX);

endpackage

// File: rtl/vector_mul_seq_if.sv
// Control/data bundle between the sequencer, its host and the polynomial multiplier.
// master = host/multiplier side, slave = vector_mul_seq.
interface vector_mul_seq_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic              mat_mode;
    logic              pol_load_coeff4x;
    logic              busy;
    logic              done;
    logic              mul_rst;
    logic              acc_clear;
    logic              result_read;
    logic              mul_done;
    logic              s_load_happens_now;
    logic [6:0]        pol_word_addr;
    logic [7:0]        s_word_addr;
    logic [ADDR_W-1:0] read_address;
    logic [63:0]       res_data;
    logic [63:0]       wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_address;

    modport master (
        output start, mat_mode, pol_load_coeff4x, mul_done, s_load_happens_now,
               pol_word_addr, s_word_addr, res_data,
        input  busy, done, mul_rst, acc_clear, result_read, read_address,
               wr_data, wr_en, wr_address
    );

    modport slave (
        input  start, mat_mode, pol_load_coeff4x, mul_done, s_load_happens_now,
               pol_word_addr, s_word_addr, res_data,
        output busy, done, mul_rst, acc_clear, result_read, read_address,
               wr_data, wr_en, wr_address
    );

endinterface

// File: rtl/vms_addr_gen.sv
// Combinational address generation: operand read address and result write address.
// All sums wrap at ADDR_W bits.
module vms_addr_gen
    import saber_pkg::*;
#(
    parameter int L_RANK   = 3,
    parameter int ADDR_W   = 11,
    parameter int RES_BASE = 1024
) (
    input  logic             mat_mode,
    input  logic             coeff4x,
    input  logic [IDX_W-1:0] row,
    input  logic [IDX_W-1:0] col,
    input  logic [5:0]       wc,
    input  logic             wr_active,
    input  logic             s_load,
    input  logic [6:0]       pol_word_addr,
    input  logic [7:0]       s_word_addr,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] wr_address
);

    logic [ADDR_W-1:0] poly_idx;
    logic [ADDR_W-1:0] pol_base;
    logic [ADDR_W-1:0] sec_base;

    always_comb begin
        // matrix mode walks the L_RANK x L_RANK matrix row-major
        poly_idx = mat_mode ? ADDR_W'(row) * ADDR_W'(L_RANK) + ADDR_W'(col) : ADDR_W'(col);
        pol_base = poly_idx * (coeff4x ? ADDR_W'(POL_STRIDE_4X) : ADDR_W'(POL_STRIDE_PACKED));
        sec_base = ADDR_W'(col) * ADDR_W'(SEC_STRIDE);
        read_address = s_load ? sec_base + ADDR_W'(s_word_addr)
                              : pol_base + ADDR_W'(pol_word_addr);
        wr_address = wr_active
                   ? ADDR_W'(RES_BASE) + ADDR_W'(row) * ADDR_W'(POLY_WORDS) + ADDR_W'(wc)
                   : '0;
    end

endmodule

// File: rtl/vector_mul_seq.sv
// Sequencer for Saber inner-product / matrix-vector multiply: drives the multiplier
// through L_RANK products per output polynomial and streams each result out.
module vector_mul_seq
    import saber_pkg::*;
#(
    parameter int L_RANK   = 3,
    parameter int ADDR_W   = 11,
    parameter int RES_BASE = 1024
) (
    input  logic           clk,
    input  logic           rst,
    vector_mul_seq_if.slave bus
);

    if (L_RANK < L_RANK_MIN || L_RANK > L_RANK_MAX) begin : g_bad_rank
        $error("vector_mul_seq: L_RANK out of range");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
    logic [5:0]       wc_q, wc_d;
    logic             mat_q, mat_d, c4x_q, c4x_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            wc_q    <= '0;
            mat_q   <= 1'b0;
            c4x_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wc_q    <= wc_d;
            mat_q   <= mat_d;
            c4x_q   <= c4x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        wc_d    = wc_q;
        mat_d   = mat_q;
        c4x_d   = c4x_q;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                mat_d   = bus.mat_mode;
                c4x_d   = bus.pol_load_coeff4x;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_CLR;
            end
            ST_CLR: state_d = ST_RUN;
            ST_RUN: if (bus.mul_done) begin
                if (col_q < IDX_W'(L_RANK - 1)) begin
                    col_d   = col_q + 1'b1;
                    state_d = ST_CLR;
                end else begin
                    wc_d    = '0;
                    state_d = ST_RDOUT;
                end
            end
            ST_RDOUT: begin
                wc_d = wc_q + 1'b1;
                if (wc_q == 6'(POLY_WORDS - 1)) begin
                    if (mat_q && row_q < IDX_W'(L_RANK - 1)) begin
                        row_d   = row_q + 1'b1;
                        col_d   = '0;
                        state_d = ST_CLR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    logic rd_active;

    always_comb begin
        bus.busy        = (state_q != ST_IDLE);
        bus.done        = (state_q == ST_DONE);
        bus.mul_rst     = (state_q == ST_CLR);
        // accumulator restarts only at the first product of each output polynomial
        bus.acc_clear   = (state_q == ST_CLR) && (col_q == '0);
        rd_active       = (state_q == ST_RDOUT);
        bus.result_read = rd_active;
        bus.wr_en       = rd_active;
    end

    assign bus.wr_data = bus.res_data;

    vms_addr_gen #(
        .L_RANK   (L_RANK),
        .ADDR_W   (ADDR_W),
        .RES_BASE (RES_BASE)
    ) u_addr_gen (
        .mat_mode      (mat_q),
        .coeff4x       (c4x_q),
        .row           (row_q),
        .col           (col_q),
        .wc            (wc_q),
        .wr_active     (rd_active),
        .s_load        (bus.s_load_happens_now),
        .pol_word_addr (bus.pol_word_addr),
        .s_word_addr   (bus.s_word_addr),
        .read_address  (bus.read_address),
        .wr_address    (bus.wr_address)
    );

endmodule

// File: tb/tb_vector_mul_seq.sv
// Directed bench for vector_mul_seq: L_RANK=3 and L_RANK=4 instances driven by a
// simple multiplier model; counts pulses/writes at negedge and checks hand-computed values.
module tb_vector_mul_seq;

    localparam logic [63:0] RES_D = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_mul_seq_if #(.ADDR_W(11)) b3 ();
    vector_mul_seq_if #(.ADDR_W(11)) b4 ();

    vector_mul_seq #(.L_RANK(3), .ADDR_W(11), .RES_BASE(1024)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    vector_mul_seq #(.L_RANK(4), .ADDR_W(11), .RES_BASE(1024)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // per-instance monitor state (index 0 = dut3, 1 = dut4)
    int          mrst_n [2];
    int          acc_n  [2];
    int          wr_n   [2];
    int          done_n [2];
    int          wd_bad [2];
    int          md_cnt [2];
    logic [10:0] wr_log [2][0:1023];
    logic [10:0] rd_log [2][0:63];

    initial for (int k = 0; k < 2; k++) begin
        mrst_n[k] = 0; acc_n[k] = 0; wr_n[k] = 0; done_n[k] = 0; wd_bad[k] = 0; md_cnt[k] = 0;
    end

    // multiplier model: product ready 3 cycles after mul_rst drops
    task automatic mon(input int k, input logic mrst, input logic acc, input logic wen,
                       input logic dn, input logic [10:0] wa, input logic [10:0] ra,
                       input logic [63:0] wd, output logic md_o);
        if (mrst) begin
            if (mrst_n[k] < 64) rd_log[k][mrst_n[k]] = ra;
            mrst_n[k]++;
            md_cnt[k] = 0;
        end else if (md_cnt[k] < 3) begin
            md_cnt[k]++;
        end
        md_o = !mrst && (md_cnt[k] >= 3);
        if (acc) acc_n[k]++;
        if (wen) begin
            if (wr_n[k] < 1024) wr_log[k][wr_n[k]] = wa;
            wr_n[k]++;
            if (wd !== RES_D) wd_bad[k]++;
        end
        if (dn) done_n[k]++;
    endtask

    always @(negedge clk) begin : mon_blk
        logic m;
        mon(0, b3.mul_rst, b3.acc_clear, b3.wr_en, b3.done, b3.wr_address, b3.read_address, b3.wr_data, m);
        b3.mul_done = m;
        mon(1, b4.mul_rst, b4.acc_clear, b4.wr_en, b4.done, b4.wr_address, b4.read_address, b4.wr_data, m);
        b4.mul_done = m;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int k, input int base, input string tag);
        int n = 0;
        while (done_n[k] == base && n < 3000) begin
            cyc();
            n++;
        end
        chk(tag, 64'(n < 3000), 64'd1);
        repeat (3) cyc();
    endtask

    task automatic contig(input int k, input int s, input int n, input string tag);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (wr_log[k][s + i] !== 11'(1024 + i)) bad++;
        chk(tag, bad, 0);
    endtask

    int s_mr, s_ac, s_wr, s_dn, s_wb;

    task automatic snap(input int k);
        s_mr = mrst_n[k]; s_ac = acc_n[k]; s_wr = wr_n[k]; s_dn = done_n[k]; s_wb = wd_bad[k];
    endtask

    initial begin
        b3.start = 0; b3.mat_mode = 0; b3.pol_load_coeff4x = 1; b3.s_load_happens_now = 1;
        b3.s_word_addr = 8'd5; b3.pol_word_addr = 7'd0; b3.res_data = RES_D;
        b4.start = 0; b4.mat_mode = 1; b4.pol_load_coeff4x = 1; b4.s_load_happens_now = 0;
        b4.s_word_addr = 8'd0; b4.pol_word_addr = 7'd0; b4.res_data = RES_D;

        cyc();
        chk("rst busy", b3.busy, 0);
        chk("rst done", b3.done, 0);
        chk("rst mul_rst", b3.mul_rst, 0);
        chk("rst acc_clear", b3.acc_clear, 0);
        chk("rst result_read", b3.result_read, 0);
        chk("rst wr_en", b3.wr_en, 0);
        chk("rst wr_address", b3.wr_address, 0);
        chk("rst busy4", b4.busy, 0);
        chk("idle read_address comb", b3.read_address, 5);
        rst = 0;
        repeat (2) cyc();

        // inner product, coeff4x, secret reads; start re-pulsed during RUN
        snap(0);
        b3.start = 1; cyc(); b3.start = 0;
        chk("A busy after start", b3.busy, 1);
        chk("A clr mul_rst", b3.mul_rst, 1);
        chk("A clr acc_clear", b3.acc_clear, 1);
        cyc();
        chk("A run mul_rst", b3.mul_rst, 0);
        b3.start = 1; cyc(); b3.start = 0;
        wait_done(0, s_dn, "A timeout");
        chk("A mul_rst pulses", mrst_n[0] - s_mr, 3);
        chk("A acc_clear pulses", acc_n[0] - s_ac, 1);
        chk("A writes", wr_n[0] - s_wr, 64);
        chk("A done pulses", done_n[0] - s_dn, 1);
        chk("A first wr", wr_log[0][s_wr], 1024);
        chk("A last wr", wr_log[0][s_wr + 63], 1087);
        contig(0, s_wr, 64, "A contiguous");
        chk("A wr_data", wd_bad[0] - s_wb, 0);
        chk("A sec addr col0", rd_log[0][s_mr], 5);
        chk("A sec addr col2", rd_log[0][s_mr + 2], 37);
        chk("A idle busy", b3.busy, 0);

        // reset in RDOUT at wc=30
        b3.s_load_happens_now = 0; b3.pol_word_addr = 7'd3;
        snap(0);
        b3.start = 1; cyc(); b3.start = 0;
        begin
            int n = 0;
            while (!(b3.wr_en && b3.wr_address == 11'd1054) && n < 3000) begin
                cyc();
                n++;
            end
            chk("R reach wc30", 64'(n < 3000), 1);
        end
        #1 rst = 1;
        #1;
        chk("R busy", b3.busy, 0);
        chk("R wr_en", b3.wr_en, 0);
        chk("R result_read", b3.result_read, 0);
        chk("R wr_address", b3.wr_address, 0);
        chk("R mul_rst", b3.mul_rst, 0);
        chk("R acc_clear", b3.acc_clear, 0);
        chk("R done", b3.done, 0);
        repeat (2) cyc();
        rst = 0;
        repeat (2) cyc();
        chk("R no done", done_n[0] - s_dn, 0);
        chk("R writes", wr_n[0] - s_wr, 31);

        // fresh run after reset
        snap(0);
        b3.start = 1; cyc(); b3.start = 0;
        wait_done(0, s_dn, "A2 timeout");
        chk("A2 done pulses", done_n[0] - s_dn, 1);
        chk("A2 writes", wr_n[0] - s_wr, 64);
        chk("A2 last wr", wr_log[0][s_wr + 63], 1087);
        chk("A2 pol addr col0", rd_log[0][s_mr], 3);
        chk("A2 pol addr col1", rd_log[0][s_mr + 1], 67);

        // matrix mode, packed operands
        b3.mat_mode = 1; b3.pol_load_coeff4x = 0; b3.pol_word_addr = 7'd0;
        snap(0);
        b3.start = 1; cyc(); b3.start = 0;
        b3.mat_mode = 0; b3.pol_load_coeff4x = 1;
        wait_done(0, s_dn, "B timeout");
        chk("B mul_rst pulses", mrst_n[0] - s_mr, 9);
        chk("B acc_clear pulses", acc_n[0] - s_ac, 3);
        chk("B writes", wr_n[0] - s_wr, 192);
        chk("B done pulses", done_n[0] - s_dn, 1);
        chk("B first wr", wr_log[0][s_wr], 1024);
        chk("B last wr", wr_log[0][s_wr + 191], 1215);
        contig(0, s_wr, 192, "B contiguous");
        chk("B base r1c2", rd_log[0][s_mr + 5], 260);
        chk("B base r2c2", rd_log[0][s_mr + 8], 416);

        // FireSaber matrix mode
        snap(1);
        b4.start = 1; cyc(); b4.start = 0;
        wait_done(1, s_dn, "C timeout");
        chk("C mul_rst pulses", mrst_n[1] - s_mr, 16);
        chk("C acc_clear pulses", acc_n[1] - s_ac, 4);
        chk("C writes", wr_n[1] - s_wr, 256);
        chk("C done pulses", done_n[1] - s_dn, 1);
        chk("C last wr", wr_log[1][s_wr + 255], 1279);
        contig(1, s_wr, 256, "C contiguous");
        chk("C base r3c3", rd_log[1][s_mr + 15], 960);
        chk("C dut3 quiet", done_n[0], 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/vector_mul_seq.md
VECTOR_MUL_SEQ -- requirements
Module: vector_mul_seq

Interface
REQ-001 SHALL have parameter L_RANK, default 3, meaning vector rank: 2 LightSaber, 3 Saber, 4 FireSaber; legal range 2..4.
REQ-002 SHALL have parameter ADDR_W, default 11, meaning virtual memory address width.
REQ-003 SHALL have parameter RES_BASE, default 1024, meaning base address of the result region.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle start pulse; sampled only in IDLE.
REQ-007 mat_mode  input  1  0 = inner product (one output polynomial); 1 = matrix-vector (L_RANK output polynomials); latched at start.
REQ-008 pol_load_coeff4x  input  1  1 = operand polynomial stored as 4x uint16 words (stride 64); 0 = packed 13-bit (stride 52); latched at start.
REQ-009 busy  output  1  high from the cycle after an accepted start until DONE exits.
REQ-010 done  output  1  one-cycle pulse when the whole operation completes.
REQ-011 mul_rst, acc_clear, result_read  output  1 each  control of the polynomial multiplier.
REQ-012 mul_done  input  1  multiplier product-complete flag.
REQ-013 s_load_happens_now  input  1  multiplier is reading a secret word; selects the read address source.
REQ-014 pol_word_addr  input  7  /  s_word_addr  input  8  word offsets from the multiplier.
REQ-015 read_address  output  ADDR_W  memory read address.
REQ-016 res_data  input  64  4 coefficients from the multiplier / wr_data  output  64  equals res_data.
REQ-017 wr_en  output  1  /  wr_address  output  ADDR_W  result write port.

Function
REQ-018 FSM states SHALL be IDLE, CLR, RUN, RDOUT, DONE.
REQ-019 IDLE: on start=1, latch the mode bits, set row=0 and col=0, and go to CLR; start in any other state SHALL be ignored.
REQ-020 CLR (one cycle): mul_rst=1; acc_clear=1 only when col=0; next state RUN.
REQ-021 RUN: mul_rst=0; hold until mul_done=1; then if col<L_RANK-1 increment col and go to CLR, else go to RDOUT with word counter wc=0.
REQ-022 RDOUT: result_read=1, wr_en=1, wr_address=RES_BASE+row*64+wc, and wc increments each cycle for 64 cycles (wc 0..63).
REQ-023 After wc=63: if mat_mode=1 and row<L_RANK-1, increment row, clear col, and go to CLR; otherwise go to DONE.
REQ-024 DONE: done=1 for one cycle, then return to IDLE.
REQ-025 Polynomial base SHALL be (mat_mode ? row*L_RANK+col : col) * (coeff4x ? 64 : 52).
REQ-026 Secret base SHALL be col*16.
REQ-027 read_address SHALL be secret base + s_word_addr when s_load_happens_now=1, else polynomial base + pol_word_addr.
REQ-028 All address arithmetic SHALL be unsigned and truncated to ADDR_W bits.
REQ-029 Outputs outside the states listed above SHALL be 0; read_address stays combinational in all states.
REQ-030 mul_done asserted outside RUN SHALL be ignored.

Reset
REQ-031 rst=1 SHALL force, asynchronously, state IDLE, row=col=wc=0, and latched mode bits to 0; busy, done, mul_rst, acc_clear, result_read, and wr_en all 0.
REQ-032 Reset mid-operation SHALL abandon the operation with no done pulse; the first start after reset release SHALL behave as from power-up.

Structure
REQ-033 A shared package saber_pkg SHALL hold: the state enum, the strides (52, 64, 16), the polynomial word count 64, and L_RANK legality bounds.
REQ-034 One sub-module, vms_addr_gen, SHALL be combinational base/address computation; the FSM and counters SHALL be in vector_mul_seq.

Verification
REQ-035 Inner product, L_RANK=3, coeff4x=1: start -> three CLR/RUN passes with acc_clear only on the first, then 64 writes at addresses 1024..1087, then exactly one done pulse.
REQ-036 Matrix mode, L_RANK=3, coeff4x=0: row 1, col 2 gives polynomial base 260; writes go to 1024..1215; 9 mul_rst pulses; 3 acc_clear pulses.
REQ-037 s_load_happens_now=1, col=2, s_word_addr=5 -> read_address=37.
REQ-038 Start asserted during RUN -> ignored; the done count stays 1.
REQ-039 rst pulse during RDOUT at wc=30 -> all outputs 0 asynchronously; no done; a new start completes normally.
REQ-040 L_RANK=4 matrix mode: 16 products, 256 writes, last wr_address 1279.
